pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter sequencer that sits directly upstream of the 8-entry return-address stack.
- Each cycle it selects the next PC from: increment, jump, taken branch, call or return.
- It drives the stack's push, pop and address inputs, and consumes the stack's top-of-stack output on return.
- It tracks call depth and halts on stack overflow or underflow, so the stack's 3-bit pointer never wraps silently.

Parameters:
ADDR_W, 12, width of PC and of every address port
STACK_DEPTH, 8, entries in the downstream stack; depth counter saturates here
RESET_PC, 12'h000, PC value loaded on reset

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  freeze sequencer this cycle; no state change, no stack strobes
jump  in  1  unconditional jump request
jump_target  in  ADDR_W  jump/call destination
branch  in  1  conditional branch instruction
branch_taken  in  1  branch condition result; meaningful only when branch=1
branch_target  in  ADDR_W  branch destination
call  in  1  subroutine call; pushes return address, goes to jump_target
ret  in  1  subroutine return
stack_top  in  ADDR_W  top-of-stack value from return stack
stack_push  out  1  push strobe to stack
stack_pop  out  1  pop strobe to stack
stack_addr  out  ADDR_W  value to push (return address)
pc  out  ADDR_W  current PC
fetch_valid  out  1  pc is a valid fetch address this cycle
depth  out  $clog2(STACK_DEPTH)+1  current call depth, 0..STACK_DEPTH
halted  out  1  sticky error: overflow or underflow occurred
overflow  out  1  sticky: call attempted at depth==STACK_DEPTH
underflow  out  1  sticky: ret attempted at depth==0

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=RUN, depth=0, halted=overflow=underflow=0. Reset asserted mid-RET_WAIT aborts the return immediately.
- Stack strobes are combinational from current state and inputs. All registered state updates on posedge clk. A new PC is visible the cycle after the request.
- fetch_valid = (state==RUN). It is low in RET_WAIT and HALT.
- RUN, stall=0, priority ret > call > jump > (branch & branch_taken) > increment:
  - ret, depth>0: stack_pop=1, depth-=1, pc holds, go to RET_WAIT.
  - ret, depth==0: no pop, underflow=1, halted=1, go to HALT.
  - call, depth<STACK_DEPTH: stack_push=1, stack_addr=pc+1 (mod 2^ADDR_W), pc<=jump_target, depth+=1.
  - call, depth==STACK_DEPTH: no push, overflow=1, halted=1, go to HALT.
  - jump: pc<=jump_target.
  - branch & taken: pc<=branch_target.
  - otherwise: pc<=pc+1. 12'hFFF wraps to 12'h000.
- RET_WAIT, stall=0: pc<=stack_top (the stack's top is valid one cycle after the pop), go to RUN. All control inputs are ignored in this state.
- Any state, stall=1: pc, state and depth hold; stack_push=stack_pop=0. A ret/call held under stall executes exactly once, on the first unstalled cycle.
- HALT: pc frozen, strobes 0, inputs ignored. Exit only via reset.
- stack_addr = pc+1 at all times; it is meaningful only while stack_push=1.
- stack_push and stack_pop are never both 1 in the same cycle.

Decomposition:
- Package pc_seq_pkg:
  - state enum {S_RUN, S_RET_WAIT, S_HALT}
  - next-PC select enum {SEL_INC, SEL_JUMP, SEL_BRANCH, SEL_CALL, SEL_RET}
  - ADDR_W and STACK_DEPTH defaults
- Sub-module pc_next_sel: purely combinational priority encoder producing the select enum from ret, call, jump, branch, branch_taken.
- FSM, depth counter and PC register live in pc_sequencer.

Test Plan:
- Reset, then 5 idle cycles -> pc 000,001,...,005; fetch_valid=1; depth=0; no strobes.
- At pc=010, call with jump_target=200 -> stack_push=1 and stack_addr=011 that cycle; next cycle pc=200, depth=1.
- At pc=203 with depth=1, ret while stack_top reads 011 in the following cycle -> stack_pop=1 for one cycle; then one RET_WAIT cycle with fetch_valid=0 and pc=203; then pc=011, depth=0.
- call+jump+branch_taken all asserted at pc=020, jump_target=300, branch_target=400 -> call wins: push 021, pc=300. Repeat with only jump+branch_taken -> pc=300.
- 8 nested calls then a 9th -> 9th produces no push, overflow=1, halted=1, pc frozen, fetch_valid=0. A ret at depth 0 after reset -> underflow=1, halted=1.
- stall held 3 cycles with call pending at pc=050 -> no strobes and pc=050 during stall; one push of 051 on release. Also: pc=FFF with no request -> pc=000 next cycle. Also: rst_n pulse during RET_WAIT -> pc=000, state RUN.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the PC sequencer.
//   state_e : sequencer FSM states
//   sel_e   : next-PC source chosen by the priority encoder
package pc_seq_pkg;

  localparam int ADDR_W_DEF      = 12;
  localparam int STACK_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_RET_WAIT = 2'd1,
    S_HALT     = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SEL_INC    = 3'd0,
    SEL_JUMP   = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_CALL   = 3'd3,
    SEL_RET    = 3'd4
  } sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the PC sequencer and the downstream return-address stack.
//   stack_push : push strobe (sequencer -> stack)
//   stack_pop  : pop strobe (sequencer -> stack)
//   stack_addr : return address to push (sequencer -> stack)
//   stack_top  : top-of-stack value (stack -> sequencer)
interface pc_sequencer_if #(
  parameter int ADDR_W = 12
);
  logic              stack_push;
  logic              stack_pop;
  logic [ADDR_W-1:0] stack_addr;
  logic [ADDR_W-1:0] stack_top;

  modport master (output stack_push, output stack_pop, output stack_addr, input stack_top);
  modport slave  (input stack_push, input stack_pop, input stack_addr, output stack_top);
endinterface

// File: rtl/pc_next_sel.sv
// Combinational priority encoder for the next-PC source.
// Priority: ret > call > jump > taken branch > increment.
//   ret, call, jump, branch, branch_taken : request inputs
//   sel                                   : chosen source
module pc_next_sel
  import pc_seq_pkg::*;
(
  input  logic ret,
  input  logic call,
  input  logic jump,
  input  logic branch,
  input  logic branch_taken,
  output sel_e sel
);

  always_comb begin
    sel = SEL_INC;
    if (ret)                      sel = SEL_RET;
    else if (call)                sel = SEL_CALL;
    else if (jump)                sel = SEL_JUMP;
    else if (branch && branch_taken) sel = SEL_BRANCH;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer feeding an 8-entry return-address stack.
// Picks the next PC each cycle, drives push/pop strobes to the stack,
// tracks call depth and halts (sticky) on stack overflow/underflow.
//   clk, rst_n        : clock, async active-low reset
//   stall             : freeze all state and suppress strobes
//   jump/jump_target  : unconditional jump (target also used by call)
//   branch/branch_taken/branch_target : conditional branch
//   call, ret         : subroutine call / return
//   stk               : stack bus (push, pop, addr out; top in)
//   pc, fetch_valid   : current PC and its validity
//   depth             : call depth 0..STACK_DEPTH
//   halted, overflow, underflow : sticky error flags
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                STACK_DEPTH = STACK_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         jump,
  input  logic [ADDR_W-1:0]            jump_target,
  input  logic                         branch,
  input  logic                         branch_taken,
  input  logic [ADDR_W-1:0]            branch_target,
  input  logic                         call,
  input  logic                         ret,
  pc_sequencer_if.master               stk,
  output logic [ADDR_W-1:0]            pc,
  output logic                         fetch_valid,
  output logic [$clog2(STACK_DEPTH):0] depth,
  output logic                         halted,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int                 DEPTH_W   = $clog2(STACK_DEPTH) + 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

  state_e            state;
  sel_e              sel;
  logic [ADDR_W-1:0] pc_inc;
  logic              active;
  logic              depth_full;
  logic              depth_empty;

  pc_next_sel u_sel (
    .ret          (ret),
    .call         (call),
    .jump         (jump),
    .branch       (branch),
    .branch_taken (branch_taken),
    .sel          (sel)
  );

  assign pc_inc      = pc + ADDR_W'(1);
  assign active      = (state == S_RUN) && !stall;
  assign depth_full  = (depth == DEPTH_MAX);
  assign depth_empty = (depth == '0);

  // Strobes only fire when the stack can actually accept them, so the
  // stack's pointer never wraps; push and pop are mutually exclusive via sel.
  assign stk.stack_push = active && (sel == SEL_CALL) && !depth_full;
  assign stk.stack_pop  = active && (sel == SEL_RET) && !depth_empty;
  assign stk.stack_addr = pc_inc;

  assign fetch_valid = (state == S_RUN);
  assign halted      = overflow | underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      pc        <= RESET_PC;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!stall) begin
      case (state)
        S_RUN: begin
          case (sel)
            SEL_RET: begin
              if (depth_empty) begin
                underflow <= 1'b1;
                state     <= S_HALT;
              end else begin
                depth <= depth - DEPTH_W'(1);
                state <= S_RET_WAIT;
              end
            end
            SEL_CALL: begin
              if (depth_full) begin
                overflow <= 1'b1;
                state    <= S_HALT;
              end else begin
                depth <= depth + DEPTH_W'(1);
                pc    <= jump_target;
              end
            end
            SEL_JUMP:   pc <= jump_target;
            SEL_BRANCH: pc <= branch_target;
            default:    pc <= pc_inc;
          endcase
        end
        // The stack presents the popped entry one cycle after the pop.
        S_RET_WAIT: begin
          pc    <= stk.stack_top;
          state <= S_RUN;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_pc_sequencer;

  localparam int AW = 12;
  localparam int SD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0, jump = 1'b0, branch = 1'b0, branch_taken = 1'b0;
  logic          call = 1'b0, ret = 1'b0;
  logic [AW-1:0] jump_target = '0, branch_target = '0;
  logic [AW-1:0] pc;
  logic          fetch_valid, halted, overflow, underflow;
  logic [3:0]    depth;

  pc_sequencer_if #(.ADDR_W(AW)) sif();

  pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD), .RESET_PC(12'h000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch        (branch),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .call          (call),
    .ret           (ret),
    .stk           (sif),
    .pc            (pc),
    .fetch_valid   (fetch_valid),
    .depth         (depth),
    .halted        (halted),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0 = fetching, 1 = waiting for return address, 2 = halted
  int m_pc, m_mode, m_depth;
  bit m_of, m_uf;

  // Environment stack and values captured at the check point of each cycle
  logic [AW-1:0] bstack[$];
  bit            c_push, c_pop, c_fv;
  int            c_addr, c_pc, c_top;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit run, e_push, e_pop;
    run    = (m_mode == 0);
    e_push = run && !stall && !ret && call && (m_depth < SD);
    e_pop  = run && !stall && ret && (m_depth > 0);
    chk("pc", int'(pc), m_pc);
    chk("fetch_valid", int'(fetch_valid), int'(run));
    chk("depth", int'(depth), m_depth);
    chk("overflow", int'(overflow), int'(m_of));
    chk("underflow", int'(underflow), int'(m_uf));
    chk("halted", int'(halted), int'(m_of | m_uf));
    chk("stack_push", int'(sif.stack_push), int'(e_push));
    chk("stack_pop", int'(sif.stack_pop), int'(e_pop));
    if (e_push) chk("stack_addr", int'(sif.stack_addr), (m_pc + 1) % (1 << AW));
    c_push = sif.stack_push;
    c_pop  = sif.stack_pop;
    c_addr = int'(sif.stack_addr);
    c_pc   = int'(pc);
    c_fv   = fetch_valid;
    c_top  = int'(sif.stack_top);
  endtask

  task automatic model_step();
    if (m_mode == 2 || stall) return;
    if (m_mode == 1) begin
      m_pc   = c_top;
      m_mode = 0;
      return;
    end
    if (ret) begin
      if (m_depth > 0) begin m_depth--; m_mode = 1; end
      else begin m_uf = 1'b1; m_mode = 2; end
    end else if (call) begin
      if (m_depth < SD) begin m_depth++; m_pc = int'(jump_target); end
      else begin m_of = 1'b1; m_mode = 2; end
    end else if (jump) m_pc = int'(jump_target);
    else if (branch && branch_taken) m_pc = int'(branch_target);
    else m_pc = (m_pc + 1) % (1 << AW);
  endtask

  task automatic cycle(bit s, bit r, bit c, bit j, logic [AW-1:0] jt,
                       bit b, bit bt_taken, logic [AW-1:0] bt);
    @(negedge clk);
    stall = s; ret = r; call = c; jump = j; jump_target = jt;
    branch = b; branch_taken = bt_taken; branch_target = bt;
    #1 check_model();
    @(posedge clk);
    #1 model_step();
    if (c_push) bstack.push_back(AW'(c_addr));
    if (c_pop && bstack.size() > 0) sif.stack_top = bstack.pop_back();
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, '0, 0, 0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    stall = 0; ret = 0; call = 0; jump = 0; branch = 0; branch_taken = 0;
    rst_n = 1'b0;
    #1;
    m_pc = 0; m_mode = 0; m_depth = 0; m_of = 0; m_uf = 0;
    bstack.delete();
    sif.stack_top = '0;
    check_model();
    chk("rst_pc", int'(pc), 'h000);
    chk("rst_fv", int'(fetch_valid), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int halt_cnt;
    sif.stack_top = '0;
    do_reset();

    for (int i = 0; i < 5; i++) begin
      idle();
      chk("idle_pc", c_pc, i);
      chk("idle_push", int'(c_push | c_pop), 0);
    end
    chk("idle_pc5", int'(pc), 'h005);

    // Call / return round trip
    cycle(0, 0, 0, 1, 12'h010, 0, 0, '0);
    chk("jump_pc", int'(pc), 'h010);
    cycle(0, 0, 1, 0, 12'h200, 0, 0, '0);
    chk("call_push", int'(c_push), 1);
    chk("call_addr", c_addr, 'h011);
    chk("call_pc", int'(pc), 'h200);
    chk("call_depth", int'(depth), 1);
    repeat (3) idle();
    chk("pre_ret_pc", int'(pc), 'h203);
    cycle(0, 1, 0, 0, '0, 0, 0, '0);
    chk("ret_pop", int'(c_pop), 1);
    idle();
    chk("wait_fv", int'(c_fv), 0);
    chk("wait_pc", c_pc, 'h203);
    chk("wait_pop", int'(c_pop), 0);
    chk("ret_pc", int'(pc), 'h011);
    chk("ret_depth", int'(depth), 0);

    // Priority
    cycle(0, 0, 0, 1, 12'h020, 0, 0, '0);
    cycle(0, 0, 1, 1, 12'h300, 1, 1, 12'h400);
    chk("prio_push", int'(c_push), 1);
    chk("prio_addr", c_addr, 'h021);
    chk("prio_pc", int'(pc), 'h300);
    cycle(0, 0, 0, 1, 12'h300, 1, 1, 12'h400);
    chk("jump_over_branch", int'(pc), 'h300);

    // Stall holding a call
    cycle(0, 0, 0, 1, 12'h050, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 1, 0, 12'h123, 0, 0, '0);
      chk("stall_push", int'(c_push), 0);
      chk("stall_pc", c_pc, 'h050);
    end
    cycle(0, 0, 1, 0, 12'h123, 0, 0, '0);
    chk("unstall_push", int'(c_push), 1);
    chk("unstall_addr", c_addr, 'h051);
    chk("unstall_depth", int'(depth), 2);

    // PC wrap
    cycle(0, 0, 0, 1, 12'hFFF, 0, 0, '0);
    idle();
    chk("wrap_pc", int'(pc), 'h000);

    // Reset during RET_WAIT
    cycle(0, 1, 0, 0, '0, 0, 0, '0);
    chk("rw_fv", int'(fetch_valid), 0);
    do_reset();
    idle();
    chk("rw_after_pc", c_pc, 'h000);
    chk("rw_after_fv", int'(c_fv), 1);

    // Overflow
    do_reset();
    for (int i = 0; i < SD; i++) cycle(0, 0, 1, 0, AW'(12'h100 + i), 0, 0, '0);
    chk("full_depth", int'(depth), 8);
    cycle(0, 0, 1, 0, 12'h777, 0, 0, '0);
    chk("ovf_push", int'(c_push), 0);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_halted", int'(halted), 1);
    chk("ovf_fv", int'(fetch_valid), 0);
    chk("ovf_pc", int'(pc), 'h107);
    cycle(0, 0, 0, 1, 12'h555, 0, 0, '0);
    chk("halt_pc", int'(pc), 'h107);

    // Underflow
    do_reset();
    cycle(0, 1, 0, 0, '0, 0, 0, '0);
    chk("udf_pop", int'(c_pop), 0);
    chk("udf_flag", int'(underflow), 1);
    chk("udf_halted", int'(halted), 1);
    chk("udf_fv", int'(fetch_valid), 0);

    // Randomized traffic
    do_reset();
    halt_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      if (m_mode == 2) begin
        halt_cnt++;
        if (halt_cnt > 3) begin do_reset(); halt_cnt = 0; end
      end
      cycle($urandom_range(99) < 20, $urandom_range(99) < 12, $urandom_range(99) < 22,
            $urandom_range(99) < 15, AW'($urandom), $urandom_range(99) < 30,
            $urandom_range(1) == 1, AW'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
